m_mem_responder: RTL and testbench

- Memory-side responder for a valid/ready request/response bus. It is the far end of the memory interface the processor drives.
- It replaces the zero-latency combinational data memory. This lets the processor be reworked to stall on a multi-cycle memory.
- It holds a word array, accepts one request at a time, and returns read data or a write acknowledge after a fixed, parameterised latency.
- Misaligned and out-of-range accesses are flagged.

---
 rtl/m_mem_responder_pkg.sv | 12 +
 rtl/m_word_ram.sv | 29 ++
 rtl/m_mem_responder.sv | 86 ++++++++
 tb/tb_m_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/m_mem_responder_pkg.sv
// m_mem_responder_pkg: shared state encoding, index width and alignment mask
//   for the memory responder and its word RAM.
`define M_MEM_IDX_W(d) (d)

package m_mem_responder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
    localparam logic [1:0] MISALIGN_MASK = 2'b11;
endpackage

// File: rtl/m_word_ram.sv
// m_word_ram: zero-initialised 32-bit word array, synchronous write, registered read.
//   clk, rst : clock, async active-high reset (clears only the read register)
//   we, re   : write / read strobes at the commit edge
//   clr      : return the read register to 0
//   idx, wd  : word index and write data
//   rd       : registered read data
module m_word_ram #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wd,
    output logic [31:0]           rd
);
    logic [31:0] mem [2**DEPTH_LOG2] = '{default: '0};

    always_ff @(posedge clk)
        if (we) mem[idx] <= wd;

    // reads see the array before any write on the same edge
    always_ff @(posedge clk or posedge rst)
        if (rst) rd <= '0;
        else if (re) rd <= mem[idx];
        else if (clr) rd <= '0;
endmodule

// File: rtl/m_mem_responder.sv
// m_mem_responder: single-outstanding valid/ready memory responder with fixed latency.
//   w_clk, w_rst            : clock, async active-high reset
//   w_req_valid/w_req_ready : request handshake; w_req_we/adr/wd request fields
//   w_rsp_valid/w_rsp_ready : response handshake; w_rsp_rd read data, w_rsp_err access error
module m_mem_responder
    import m_mem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [31:0] w_req_adr,
    input  logic [31:0] w_req_wd,
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_rd,
    output logic        w_rsp_err
);
    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_adr, lat_wd;
    logic        c_we, c_err, commit;
    logic [31:0] c_adr, c_wd;
    logic [`M_MEM_IDX_W(DEPTH_LOG2)-1:0] idx;

    assign w_req_ready = (state == IDLE) && !w_rst;

    // with LATENCY == 1 the commit edge is the acceptance edge, so use the live request
    always_comb begin
        c_we   = (state == IDLE) ? w_req_we  : lat_we;
        c_adr  = (state == IDLE) ? w_req_adr : lat_adr;
        c_wd   = (state == IDLE) ? w_req_wd  : lat_wd;
        c_err  = |(c_adr[1:0] & MISALIGN_MASK) | |c_adr[31:DEPTH_LOG2+2];
        idx    = c_adr[DEPTH_LOG2+1:2];
        commit = (state == IDLE && w_req_valid && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    end

    m_word_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk (w_clk),
        .rst (w_rst),
        .we  (commit && c_we && !c_err),
        .re  (commit && !c_we && !c_err),
        .clr (state == RESP && w_rsp_ready),
        .idx (idx),
        .wd  (c_wd),
        .rd  (w_rsp_rd)
    );

    always_ff @(posedge w_clk or posedge w_rst)
        if (w_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_we      <= 1'b0;
            lat_adr     <= '0;
            lat_wd      <= '0;
            w_rsp_valid <= 1'b0;
            w_rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (w_req_valid) begin
                    lat_we  <= w_req_we;
                    lat_adr <= w_req_adr;
                    lat_wd  <= w_req_wd;
                    cnt     <= 4'(LATENCY - 1);
                    state   <= (LATENCY > 1) ? WAIT : RESP;
                end
                WAIT: cnt <= cnt - 4'd1;
                RESP: if (w_rsp_ready) begin
                    state       <= IDLE;
                    w_rsp_valid <= 1'b0;
                    w_rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (commit) begin
                state       <= RESP;
                w_rsp_valid <= 1'b1;
                w_rsp_err   <= c_err;
            end
        end
endmodule

// File: tb/tb_m_mem_responder.sv
// tb_m_mem_responder: directed + randomized checks of three responder builds
//   (LATENCY 2, 1, 4) against a word-array reference model.
module tb_m_mem_responder;
    localparam int LATS [3] = '{2, 1, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv [3], rqr [3], we [3], rsv [3], rr [3], rse [3];
    logic [31:0] adr [3], wd [3], rd [3];
    logic [31:0] mdl [3][64];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        m_mem_responder #(.DEPTH_LOG2(6), .LATENCY(LATS[g])) u_dut (
            .w_clk       (clk),
            .w_rst       (rst),
            .w_req_valid (rv[g]),
            .w_req_ready (rqr[g]),
            .w_req_we    (we[g]),
            .w_req_adr   (adr[g]),
            .w_req_wd    (wd[g]),
            .w_rsp_valid (rsv[g]),
            .w_rsp_ready (rr[g]),
            .w_rsp_rd    (rd[g]),
            .w_rsp_err   (rse[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 8) != 0);
    endfunction

    // one full transaction on build d, with bp cycles of response backpressure
    task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] v, input int bp);
        logic        e;
        logic [31:0] exp_rd, s_rd;
        logic        s_err;
        int          n;
        e      = is_err(a);
        exp_rd = (!w && !e) ? mdl[d][a[7:2]] : 32'h0;
        if (w && !e) mdl[d][a[7:2]] = v;
        n = 0;
        while (!rqr[d] && n < 50) begin step(); n++; end
        chk("req_ready_idle", 32'(rqr[d]), 32'd1);
        rv[d] = 1'b1; we[d] = w; adr[d] = a; wd[d] = v;
        step();
        rv[d] = 1'b0; we[d] = $urandom_range(0, 1); adr[d] = $urandom; wd[d] = $urandom;
        n = 0;
        while (!rsv[d] && n < 20) begin step(); n++; end
        chk($sformatf("latency_L%0d", LATS[d]), 32'(n), 32'(LATS[d] - 1));
        chk("rsp_rd", rd[d], exp_rd);
        chk("rsp_err", 32'(rse[d]), 32'(e));
        s_rd = rd[d]; s_err = rse[d];
        for (int i = 0; i < bp; i++) begin
            rv[d] = 1'b1;
            step();
            chk("bp_valid", 32'(rsv[d]), 32'd1);
            chk("bp_rd", rd[d], s_rd);
            chk("bp_err", 32'(rse[d]), 32'(s_err));
            chk("bp_req_ready", 32'(rqr[d]), 32'd0);
        end
        rv[d] = 1'b0; rr[d] = 1'b1;
        step();
        rr[d] = 1'b0;
        chk("hs_valid", 32'(rsv[d]), 32'd0);
        chk("hs_rd", rd[d], 32'h0);
        chk("hs_err", 32'(rse[d]), 32'd0);
    endtask

    // back-to-back reads with valid and rsp_ready held high; checks accept spacing
    task automatic b2b(input int d);
        int acc [$];
        int rise;
        logic r, pv;
        rise = -1; pv = 1'b0;
        rv[d] = 1'b1; we[d] = 1'b0; adr[d] = 32'h10; rr[d] = 1'b1;
        for (int e = 1; e <= 3 * (LATS[d] + 1) + 1; e++) begin
            r = rqr[d];
            step();
            if (r) acc.push_back(e);
            if (rsv[d] && !pv && rise < 0) rise = e;
            pv = rsv[d];
        end
        rv[d] = 1'b0;
        chk("b2b_accepts", 32'(acc.size() >= 3), 32'd1);
        if (acc.size() >= 3) begin
            chk($sformatf("b2b_spacing_L%0d", LATS[d]), 32'(acc[1] - acc[0]), 32'(LATS[d] + 1));
            chk($sformatf("b2b_spacing2_L%0d", LATS[d]), 32'(acc[2] - acc[1]), 32'(LATS[d] + 1));
            chk($sformatf("b2b_rise_L%0d", LATS[d]), 32'(rise), 32'(acc[0] + LATS[d] - 1));
        end
        for (int i = 0; i < LATS[d] + 2; i++) step();
        rr[d] = 1'b0;
        chk("b2b_idle", 32'(rqr[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        for (int d = 0; d < 3; d++) begin
            rv[d] = 0; we[d] = 0; rr[d] = 0; adr[d] = 0; wd[d] = 0;
            for (int i = 0; i < 64; i++) mdl[d][i] = 32'h0;
        end
        #2;
        chk("rst_ready", 32'(rqr[0]), 32'd0);
        chk("rst_valid", 32'(rsv[0]), 32'd0);
        chk("rst_rd", rd[0], 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("ready_after_release", 32'(rqr[0]), 32'd1);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 5);
        txn(0, 1'b1, 32'h13, 32'h5, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 0);
        txn(0, 1'b0, 32'h100, 32'h0, 0);

        // async reset while a read response is pending
        rv[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10;
        step();
        rv[0] = 1'b0;
        step();
        chk("pre_rst_rd", rd[0], 32'hDEADBEEF);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(rsv[0]), 32'd0);
        chk("async_rst_rd", rd[0], 32'h0);
        chk("async_rst_ready", 32'(rqr[0]), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(rqr[0]), 32'd1);

        // reset in WAIT on the LATENCY=4 build drops the write
        rv[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; wd[2] = 32'h7;
        step();
        rv[2] = 1'b0;
        step();
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        txn(2, 1'b0, 32'h20, 32'h0, 0);
        chk("wait_rst_dropped", mdl[2][8], 32'h0);

        txn(1, 1'b1, 32'h10, 32'hCAFE0001, 0);
        txn(2, 1'b1, 32'h10, 32'hCAFE0004, 0);
        for (int d = 0; d < 3; d++) b2b(d);

        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 25; k++) begin
                a = 32'($urandom_range(0, 15)) << 2;
                case ($urandom_range(0, 5))
                    0: a = a + 32'($urandom_range(1, 3));
                    1: a = a | (32'h1 << $urandom_range(8, 31));
                    default: ;
                endcase
                txn(d, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
            end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
